ps2_receptor: RTL and testbench

//  Byte-level PS/2 keyboard receiver that sits directly upstream of the key decoder ("entrada").

---
 rtl/ps2_receptor.sv | 136 +++++++++++++
 tb/tb_ps2_receptor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_receptor.sv
// PS/2 keyboard byte receiver: synchronises the PS/2 lines, deframes 11-bit frames and
// folds 0xE0/0xF0 prefixes into flags, presenting each key event with a one-cycle valido.
module ps2_receptor #(
  parameter int unsigned TIMEOUT_CICLOS = 16384,
  parameter int unsigned SINC_ESTAGIOS  = 2
) (
  input  logic       relogio50,
  input  logic       inicializa,
  input  logic       ps2relogio,
  input  logic       ps2dados,
  output logic [7:0] codigo,
  output logic       solta,
  output logic       estendida,
  output logic       valido,
  output logic       erro
);

  localparam int unsigned CW = $clog2(TIMEOUT_CICLOS);
  localparam logic [CW-1:0] SATURA  = CW'(TIMEOUT_CICLOS - 1);
  // Counter lags the borda cycle by one and erro is registered, so firing at T-3
  // makes erro rise exactly TIMEOUT_CICLOS-1 cycles after the last borda.
  localparam logic [CW-1:0] DISPARO = CW'(TIMEOUT_CICLOS - 3);

  typedef enum logic [1:0] {
    OCIOSO,
    DADOS,
    PARIDADE,
    PARADA
  } estado_t;

  estado_t                  estado;
  logic [SINC_ESTAGIOS-1:0] sinc_rel;
  logic [SINC_ESTAGIOS-1:0] sinc_dad;
  logic                     rel_ant;
  logic                     rel_s;
  logic                     dad_s;
  logic                     borda;
  logic [2:0]               nbits;
  logic [7:0]               desloc;
  logic                     paridade;
  logic [CW-1:0]            ociosidade;
  logic                     pend_est;
  logic                     pend_solta;

  always_comb begin
    rel_s = sinc_rel[SINC_ESTAGIOS-1];
    dad_s = sinc_dad[SINC_ESTAGIOS-1];
    borda = rel_ant & ~rel_s;
  end

  always_ff @(posedge relogio50 or posedge inicializa) begin
    if (inicializa) begin
      sinc_rel <= '1;
      sinc_dad <= '1;
      rel_ant  <= 1'b1;
    end else begin
      sinc_rel <= {sinc_rel[SINC_ESTAGIOS-2:0], ps2relogio};
      sinc_dad <= {sinc_dad[SINC_ESTAGIOS-2:0], ps2dados};
      rel_ant  <= rel_s;
    end
  end

  always_ff @(posedge relogio50 or posedge inicializa) begin
    if (inicializa) begin
      estado     <= OCIOSO;
      nbits      <= '0;
      desloc     <= '0;
      paridade   <= 1'b0;
      ociosidade <= '0;
      pend_est   <= 1'b0;
      pend_solta <= 1'b0;
      codigo     <= '0;
      solta      <= 1'b0;
      estendida  <= 1'b0;
      valido     <= 1'b0;
      erro       <= 1'b0;
    end else begin
      valido <= 1'b0;
      erro   <= 1'b0;

      if (borda)
        ociosidade <= '0;
      else if (ociosidade != SATURA)
        ociosidade <= ociosidade + 1'b1;

      if (borda) begin
        case (estado)
          OCIOSO: begin
            if (!dad_s) begin
              estado <= DADOS;
              nbits  <= '0;
            end
          end
          DADOS: begin
            desloc <= {dad_s, desloc[7:1]};
            nbits  <= nbits + 1'b1;
            if (nbits == 3'd7)
              estado <= PARIDADE;
          end
          PARIDADE: begin
            paridade <= dad_s;
            estado   <= PARADA;
          end
          PARADA: begin
            estado <= OCIOSO;
            if (dad_s && (^desloc ^ paridade)) begin
              if (desloc == 8'hE0)
                pend_est <= 1'b1;
              else if (desloc == 8'hF0)
                pend_solta <= 1'b1;
              else begin
                codigo     <= desloc;
                solta      <= pend_solta;
                estendida  <= pend_est;
                valido     <= 1'b1;
                pend_est   <= 1'b0;
                pend_solta <= 1'b0;
              end
            end else begin
              erro       <= 1'b1;
              pend_est   <= 1'b0;
              pend_solta <= 1'b0;
            end
          end
          default: estado <= OCIOSO;
        endcase
      end else if (estado != OCIOSO && ociosidade == DISPARO) begin
        estado     <= OCIOSO;
        erro       <= 1'b1;
        pend_est   <= 1'b0;
        pend_solta <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_receptor.sv
// Directed bench for ps2_receptor: PS/2 frames at 60 us period, scoreboard of expected strobes.
module tb_ps2_receptor;

  localparam int unsigned T    = 512;
  localparam int unsigned S    = 2;
  localparam int          MEIO = 60;  // relogio50 cycles per PS/2 half period (30 us at 500 ns)

  logic       relogio50  = 1'b0;
  logic       inicializa = 1'b1;
  logic       ps2relogio = 1'b1;
  logic       ps2dados   = 1'b1;
  logic [7:0] codigo;
  logic       solta;
  logic       estendida;
  logic       valido;
  logic       erro;

  int     errors = 0;
  int     checks = 0;
  longint ciclo  = 0;

  typedef struct {
    logic [11:0] sinal;  // {valido, erro, codigo, solta, estendida}
    longint      ciclo;  // expected sample cycle, -1 = don't care
  } evento_t;

  evento_t    sb[$];
  evento_t    ev;
  logic       strobe_ant = 1'b0;
  logic [7:0] m_cod = 8'h00;
  logic       m_sol = 1'b0;
  logic       m_est = 1'b0;
  logic       p_est = 1'b0;
  logic       p_sol = 1'b0;

  ps2_receptor #(
    .TIMEOUT_CICLOS(T),
    .SINC_ESTAGIOS (S)
  ) dut (
    .relogio50 (relogio50),
    .inicializa(inicializa),
    .ps2relogio(ps2relogio),
    .ps2dados  (ps2dados),
    .codigo    (codigo),
    .solta     (solta),
    .estendida (estendida),
    .valido    (valido),
    .erro      (erro)
  );

  always #250 relogio50 = ~relogio50;

  always @(posedge relogio50) ciclo++;

  always @(negedge relogio50) begin
    if (valido || erro) begin
      checks++;
      assert (strobe_ant === 1'b0)
        else begin errors++; $error("FAIL strobe_width obs_prev=%b exp_prev=0 at ciclo %0d", strobe_ant, ciclo); end
      checks++;
      assert (sb.size() > 0)
        else begin errors++; $error("FAIL unexpected_strobe obs valido=%b erro=%b codigo=%h exp no strobe", valido, erro, codigo); end
      if (sb.size() > 0) begin
        ev = sb.pop_front();
        checks++;
        assert ({valido, erro, codigo, solta, estendida} === ev.sinal)
          else begin errors++; $error("FAIL strobe_fields obs=%h exp=%h", {valido, erro, codigo, solta, estendida}, ev.sinal); end
        if (ev.ciclo >= 0) begin
          checks++;
          assert (ciclo === ev.ciclo)
            else begin errors++; $error("FAIL strobe_cycle obs=%0d exp=%0d", ciclo, ev.ciclo); end
        end
      end
    end
    strobe_ant = valido || erro;
  end

  task automatic meio_periodo();
    repeat (MEIO) @(negedge relogio50);
  endtask

  task automatic envia_bits(input logic [10:0] bits, input int n, output longint ult_borda);
    ult_borda = -1;
    for (int i = 0; i < n; i++) begin
      ps2dados = bits[i];
      meio_periodo();
      ps2relogio = 1'b0;
      ult_borda  = ciclo;
      meio_periodo();
      ps2relogio = 1'b1;
    end
  endtask

  function automatic logic [10:0] quadro(input logic [7:0] b, input logic par_errada, input logic stop);
    return {stop, ~(^b) ^ par_errada, b, 1'b0};
  endfunction

  task automatic espera_codigo(input logic [7:0] b, input longint c);
    evento_t e;
    if (b == 8'hE0) p_est = 1'b1;
    else if (b == 8'hF0) p_sol = 1'b1;
    else begin
      m_cod = b; m_sol = p_sol; m_est = p_est;
      p_est = 1'b0; p_sol = 1'b0;
      e.sinal = {2'b10, m_cod, m_sol, m_est};
      e.ciclo = c;
      sb.push_back(e);
    end
  endtask

  task automatic espera_erro(input longint c);
    evento_t e;
    p_est = 1'b0; p_sol = 1'b0;
    e.sinal = {2'b01, m_cod, m_sol, m_est};
    e.ciclo = c;
    sb.push_back(e);
  endtask

  // Must be entered right after a negedge; stop-bit borda lands 21 half periods later.
  task automatic envia_quadro(input logic [7:0] b, input logic par_errada, input logic stop);
    longint lb;
    longint c_esp;
    c_esp = ciclo + MEIO * 21 + S + 1;
    if (!par_errada && stop) espera_codigo(b, c_esp);
    else espera_erro(c_esp);
    envia_bits(quadro(b, par_errada, stop), 11, lb);
    repeat (100) @(negedge relogio50);
  endtask

  task automatic confere_saida(input string tag);
    checks++;
    assert ({codigo, solta, estendida} === {m_cod, m_sol, m_est})
      else begin errors++; $error("FAIL %s obs=%h/%b/%b exp=%h/%b/%b", tag, codigo, solta, estendida, m_cod, m_sol, m_est); end
  endtask

  initial begin
    longint lb;
    repeat (5) @(negedge relogio50);
    checks++;
    assert ({codigo, solta, estendida, valido, erro} === 12'h000)
      else begin errors++; $error("FAIL reset_state obs=%h exp=000", {codigo, solta, estendida, valido, erro}); end
    inicializa = 1'b0;
    repeat (20) @(negedge relogio50);

    envia_quadro(8'h1C, 1'b0, 1'b1);
    confere_saida("t1_plain");

    envia_quadro(8'hF0, 1'b0, 1'b1);
    envia_quadro(8'h1C, 1'b0, 1'b1);
    confere_saida("t2_release");
    envia_quadro(8'hE0, 1'b0, 1'b1);
    envia_quadro(8'hF0, 1'b0, 1'b1);
    envia_quadro(8'h75, 1'b0, 1'b1);
    confere_saida("t2_ext_release");

    envia_quadro(8'h1C, 1'b1, 1'b1);
    confere_saida("t3_parity_hold");
    envia_quadro(8'hE0, 1'b0, 1'b1);
    envia_quadro(8'h33, 1'b1, 1'b1);
    envia_quadro(8'h75, 1'b0, 1'b1);
    confere_saida("t3_prefix_dropped");

    envia_bits(quadro(8'h3A, 1'b0, 1'b1), 6, lb);
    espera_erro(lb + S + T - 1);
    repeat (T + 50) @(negedge relogio50);
    confere_saida("t4_timeout_hold");
    envia_quadro(8'h3A, 1'b0, 1'b1);
    confere_saida("t4_after_timeout");

    envia_quadro(8'h42, 1'b0, 1'b0);
    confere_saida("t5_stop_hold");
    ps2dados = 1'b1;
    meio_periodo();
    ps2relogio = 1'b0;
    meio_periodo();
    ps2relogio = 1'b1;
    repeat (100) @(negedge relogio50);
    envia_quadro(8'h29, 1'b0, 1'b1);
    confere_saida("t5_after_spurious");

    envia_bits(quadro(8'h55, 1'b0, 1'b1), 5, lb);
    @(negedge relogio50);
    inicializa = 1'b1;
    #1;
    checks++;
    assert ({codigo, solta, estendida, valido, erro} === 12'h000)
      else begin errors++; $error("FAIL t6_async_reset obs=%h exp=000", {codigo, solta, estendida, valido, erro}); end
    m_cod = 8'h00; m_sol = 1'b0; m_est = 1'b0; p_est = 1'b0; p_sol = 1'b0;
    repeat (5) @(negedge relogio50);
    inicializa = 1'b0;
    repeat (20) @(negedge relogio50);
    envia_quadro(8'h76, 1'b0, 1'b1);
    confere_saida("t6_after_reset");

    repeat (50) @(negedge relogio50);
    checks++;
    assert (sb.size() == 0)
      else begin errors++; $error("FAIL pending_events obs=%0d exp=0", sb.size()); end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
